// File: rtl/seq_mult_8bit.sv
// Sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: start at edge E, done in the cycle after edge E+WIDTH, next start at E+WIDTH+2.
// Backpressure: none; start is only honoured in IDLE, otherwise dropped.
module seq_mult_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Ain,
    input  logic [WIDTH-1:0]     Bin,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Pout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   acc_sum;
    logic               c;
    logic [2*WIDTH-1:0] acc_q_nxt;

    // One iteration: add with carry-out, then shift {c,acc,q} right by one.
    // The shifted-in MSB is always zero, so only the low 2*WIDTH bits are kept.
    always_comb begin
        addend      = q[0] ? m : '0;
        {c, acc_sum} = {1'b0, acc} + {1'b0, addend};
        acc_q_nxt   = {c, acc_sum, q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m    <= '0;
            acc  <= '0;
            q    <= '0;
            cnt  <= '0;
            Pout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= Ain;
                        q   <= Bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    {acc, q} <= acc_q_nxt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Pout <= acc_q_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Self-checking bench for seq_mult_8bit: vector table, random products, handshake corners.
module tb_seq_mult_8bit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  Ain;
    logic [7:0]  Bin;
    logic        busy;
    logic        done;
    logic [15:0] Pout;

    int tests = 0;
    int fails = 0;

    seq_mult_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Ain   (Ain),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Pout  (Pout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at a negedge, DUT idle again.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input string name);
        int n;
        bit seen;
        Ain   = a;
        Bin   = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_rise"}, 32'(busy), 32'd1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({name, " done_latency"}, seen ? 32'(n) : 32'd0, 32'd9);
        check({name, " product"}, 32'(Pout), 32'(exp));
        @(negedge clk);
        check({name, " busy_fall"}, 32'(busy), 32'd0);
        check({name, " done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   done_cnt;
        logic [15:0] last_p;
        int   dcyc[5];
        bit   bus[64];
        int   nd;
        int   idle_between;

        vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hFF, 16'h0000};
        vecs[3] = '{8'h80, 8'h02, 16'h0100};
        vecs[4] = '{8'h01, 8'hFF, 16'h00FF};
        vecs[5] = '{8'hFF, 8'h01, 16'h00FF};

        rst   = 1'b1;
        start = 1'b0;
        Ain   = 8'h00;
        Bin   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pout", 32'(Pout), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_mult(ra, rb, 16'(ra) * 16'(rb), $sformatf("rand%0d", i));
        end

        // Start arriving mid-run must be dropped.
        Ain = 8'h03; Bin = 8'h05; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        Ain = 8'h77; Bin = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        last_p   = 16'hDEAD;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                last_p = Pout;
            end
        end
        check("ignored_start done_count", 32'(done_cnt), 32'd1);
        check("ignored_start product", 32'(last_p), 32'h000F);

        // Start held high relaunches every WIDTH+2 cycles.
        Ain = 8'h10; Bin = 8'h10; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 5; i++) dcyc[i] = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            bus[i] = busy;
            if (done) begin
                if (nd < 5) dcyc[nd] = i;
                nd++;
                check($sformatf("held product%0d", nd), 32'(Pout), 32'h0100);
            end
        end
        start = 1'b0;
        check("held done_count_min3", 32'(nd >= 3), 32'd1);
        check("held period1", 32'(dcyc[1] - dcyc[0]), 32'd10);
        check("held period2", 32'(dcyc[2] - dcyc[1]), 32'd10);
        idle_between = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i > dcyc[0] && i < dcyc[1] && !bus[i]) idle_between++;
        end
        check("held idle_gap", 32'(idle_between), 32'd1);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held settle", 32'(busy), 32'd0);

        // Reset mid-run abandons the operation.
        run_mult(8'h0D, 8'h0B, 16'h008F, "pre_reset");
        Ain = 8'h02; Bin = 8'h02; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst pout", 32'(Pout), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("midrst no_activity", 32'(done_cnt), 32'd0);
        run_mult(8'h02, 8'h03, 16'h0006, "post_reset");

        // Operand changes while idle must not disturb the held product.
        run_mult(8'h0D, 8'h0B, 16'h008F, "hold");
        for (int i = 0; i < 5; i++) begin
            Ain = 8'($urandom);
            Bin = 8'($urandom);
            @(negedge clk);
            check($sformatf("hold idle%0d", i), 32'(Pout), 32'h008F);
        end
        // Product also stays put during the next run until its done.
        Ain = 8'h05; Bin = 8'h05; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        Ain = 8'hAA; Bin = 8'h55;
        repeat (4) @(negedge clk);
        check("hold during_run", 32'(Pout), 32'h008F);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold next_product", 32'(Pout), 32'h0019);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
